// File: rtl/gearbox_tx_param.sv
// Transmit width-reduction gearbox: IN_W-bit words in, OUT_W-bit words out, LSB first.
// The output side cannot stall. Input starvation shows up as dout_valid gaps, never as stale data.
module gearbox_tx_param #(
   parameter int IN_W   = 66,
   parameter int OUT_W  = 20,
   parameter int FILL_W = $clog2(IN_W + OUT_W)
) (
   input  logic              clk_i,
   input  logic              sclr_i,
   input  logic [IN_W-1:0]   din_i,
   input  logic              din_valid_i,
   output logic              din_ready_o,
   output logic [OUT_W-1:0]  dout_o,
   output logic              dout_valid_o,
   output logic [FILL_W-1:0] fill_o
);
   localparam int                ST_W    = IN_W + OUT_W - 1;
   localparam logic [FILL_W-1:0] OUT_CNT = FILL_W'(OUT_W);
   localparam logic [FILL_W-1:0] IN_CNT  = FILL_W'(IN_W);

   logic [ST_W-1:0]   store_q, store_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [OUT_W-1:0]  dout_q, dout_d;
   logic              dout_valid_q, dout_valid_d;

   logic              emit, take;
   logic [FILL_W-1:0] fill_rem;
   logic [ST_W-1:0]   store_shift, din_ext, din_mask;

   always_comb begin
      emit         = (fill_q >= OUT_CNT);
      fill_rem     = emit ? (fill_q - OUT_CNT) : fill_q;
      // ready depends only on the registered fill, never on din_valid
      din_ready_o  = (fill_rem < OUT_CNT);
      take         = din_ready_o & din_valid_i;

      store_shift  = emit ? (store_q >> OUT_W) : store_q;
      din_ext      = ST_W'(din_i) << fill_rem;
      din_mask     = ST_W'({IN_W{1'b1}}) << fill_rem;
      store_d      = take ? ((store_shift & ~din_mask) | din_ext) : store_shift;

      fill_d       = fill_rem + (take ? IN_CNT : '0);
      dout_d       = emit ? store_q[OUT_W-1:0] : dout_q;
      dout_valid_d = emit;
   end

   always_ff @(posedge clk_i) begin
      if (sclr_i) begin
         fill_q       <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         fill_q       <= fill_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   // Storage is deliberately left uncleared: fill alone decides which bits are live.
   always_ff @(posedge clk_i) begin
      store_q <= store_d;
   end

   assign dout_o       = dout_q;
   assign dout_valid_o = dout_valid_q;
   assign fill_o       = fill_q;

endmodule

// File: tb/tb_gearbox_tx_param.sv
// Bench for gearbox_tx_param: directed 66:20 scenarios against a bit-level scoreboard,
// plus free-running integrity sweeps over other width pairs.
`timescale 1ns/1ps
module tb_gearbox_tx_param;
   localparam int IW = 66;
   localparam int OW = 20;
   localparam int FW = $clog2(IW + OW);
   localparam int NW = 200;

   logic          clk = 1'b0;
   logic          sclr = 1'b0;
   logic [IW-1:0] din = '0;
   logic          din_valid = 1'b0;
   logic          din_ready;
   logic [OW-1:0] dout;
   logic          dout_valid;
   logic [FW-1:0] fill;

   logic          sw_sclr = 1'b0;
   logic          sw_run = 1'b0;

   int            checks = 0;
   int            failures = 0;
   int            r_m = 0;
   int            accepted = 0;
   logic          exp_dv = 1'b0;
   logic [OW-1:0] last_dout = '0;
   bit            exp_q[$];

   always #5 clk = ~clk;

   gearbox_tx_param #(.IN_W(IW), .OUT_W(OW)) u_dut (
      .clk_i(clk), .sclr_i(sclr), .din_i(din), .din_valid_i(din_valid),
      .din_ready_o(din_ready), .dout_o(dout), .dout_valid_o(dout_valid), .fill_o(fill)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sw_in(input int g);
      return (g == 3) ? 64 : 66;
   endfunction

   function automatic int sw_out(input int g);
      case (g)
         0: return 32;
         1: return 40;
         2: return 66;
         3: return 16;
         default: return 1;
      endcase
   endfunction

   function automatic logic ready_sched(input int m);
      return (m == 0 || m == 3 || m == 6 || m == 9 || m == 13 || m == 16 ||
              m == 19 || m == 23 || m == 26 || m == 29);
   endfunction

   function automatic logic [FW-1:0] fill_start(input int k);
      case (k)
         0: return 7'd0;
         1: return 7'd66;
         2: return 7'd46;
         3: return 7'd26;
         default: return 7'd72;
      endcase
   endfunction

   // One clock of the 66:20 DUT. Called just after a falling edge; returns just after the next one.
   task automatic cycle(input logic v, input logic rst);
      logic          emit, rdy, take;
      int            rp;
      logic [IW-1:0] w;
      logic [OW-1:0] ew;
      w    = IW'({$urandom(), $urandom(), $urandom()});
      emit = (r_m >= OW);
      rp   = emit ? r_m - OW : r_m;
      rdy  = (rp < OW);
      if (!rst) chk("din_ready", 128'(din_ready), 128'(rdy));
      take = v && rdy && !rst;
      din = w;
      din_valid = v;
      sclr = rst;
      if (take) begin
         for (int i = 0; i < IW; i++) exp_q.push_back(w[i]);
         accepted++;
      end
      @(posedge clk);
      @(negedge clk);
      sclr = 1'b0;
      if (rst) begin
         r_m = 0;
         exp_dv = 1'b0;
         last_dout = '0;
         exp_q.delete();
      end else begin
         r_m = rp + (take ? IW : 0);
         exp_dv = emit;
      end
      chk("fill", 128'(fill), 128'(r_m));
      chk("fill_max", 128'(fill <= 7'd85), 128'(1'b1));
      chk("dout_valid", 128'(dout_valid), 128'(exp_dv));
      if (dout_valid === 1'b1) begin
         if (exp_q.size() < OW) chk("underrun", 128'(exp_q.size()), 128'(OW));
         else begin
            for (int i = 0; i < OW; i++) ew[i] = exp_q.pop_front();
            chk("dout", 128'(dout), 128'(ew));
            last_dout = ew;
         end
      end else begin
         chk("dout_hold", 128'(dout), 128'(last_dout));
      end
   endtask

   for (genvar g = 0; g < 5; g++) begin : g_sweep
      localparam int SI = sw_in(g);
      localparam int SO = sw_out(g);
      logic [SI-1:0]              s_din = '0;
      logic                       s_dv = 1'b0;
      logic                       s_dr;
      logic [SO-1:0]              s_dout;
      logic                       s_dov;
      logic [$clog2(SI+SO)-1:0]   s_fill;
      logic                       done = 1'b0;
      int                         n_acc = 0;
      bit                         q[$];

      gearbox_tx_param #(.IN_W(SI), .OUT_W(SO)) u_dut (
         .clk_i(clk), .sclr_i(sw_sclr), .din_i(s_din), .din_valid_i(s_dv),
         .din_ready_o(s_dr), .dout_o(s_dout), .dout_valid_o(s_dov), .fill_o(s_fill)
      );

      initial forever begin
         logic [SO-1:0] ew;
         @(negedge clk);
         if (sw_sclr) begin
            q.delete();
            n_acc = 0;
            s_dv = 1'b0;
            done = 1'b0;
         end else if (sw_run && !done) begin
            if (s_dov === 1'b1) begin
               if (q.size() < SO) chk("sw_underrun", 128'(q.size()), 128'(SO));
               else begin
                  for (int i = 0; i < SO; i++) ew[i] = q.pop_front();
                  chk("sw_dout", 128'(s_dout), 128'(ew));
               end
            end
            chk("sw_fill_max", 128'(s_fill <= SI + SO - 1), 128'(1'b1));
            if (n_acc < NW) begin
               s_din = SI'({$urandom(), $urandom(), $urandom()});
               s_dv = 1'b1;
            end else begin
               s_dv = 1'b0;
            end
            if (s_dv && s_dr === 1'b1) begin
               for (int i = 0; i < SI; i++) q.push_back(s_din[i]);
               n_acc++;
            end
            if (n_acc >= NW && q.size() < SO) done = 1'b1;
         end
      end

      if (g == 2) begin : g_pt
         logic [1:0] hist = 2'b00;
         initial forever begin
            @(posedge clk);
            hist = sw_sclr ? 2'b00 : {hist[0], s_dv & s_dr};
         end
         initial forever begin
            @(negedge clk);
            if (sw_run && !sw_sclr) begin
               chk("pt_ready", 128'(s_dr), 128'(1'b1));
               chk("pt_latency", 128'(s_dov), 128'(hist[1]));
            end
         end
      end
   end

   initial begin
      logic all_done;
      int   dens [3] = '{30, 60, 90};
      @(negedge clk);

      // reset state
      cycle(1'b0, 1'b1);
      chk("rst0_fill", 128'(fill), 128'(0));
      chk("rst0_dv", 128'(dout_valid), 128'(0));
      chk("rst0_dout", 128'(dout), 128'(0));
      chk("rst0_ready", 128'(din_ready), 128'(1));

      // continuous stream: ready schedule, start-up fill, gapless output
      for (int k = 0; k < 66; k++) begin
         chk("ready_sched", 128'(din_ready), 128'(ready_sched(k % 33)));
         if (k < 5) chk("fill_start", 128'(fill), 128'(fill_start(k)));
         if (k >= 2) chk("dv_cont", 128'(dout_valid), 128'(1'b1));
         cycle(1'b1, 1'b0);
      end
      for (int c = 0; c < 5000 && accepted < 1000; c++) cycle(1'b1, 1'b0);
      chk("accept_1000", 128'(accepted >= 1000), 128'(1'b1));

      // starvation gap starting where ready is high
      for (int c = 0; c < 6 && din_ready !== 1'b1; c++) cycle(1'b1, 1'b0);
      for (int c = 0; c < 5; c++) begin
         chk("gap_ready", 128'(din_ready), 128'(1'b1));
         cycle(1'b0, 1'b0);
      end
      for (int c = 0; c < 60; c++) cycle(1'b1, 1'b0);

      // reset mid-stream at fill=58, with a word offered in the reset cycle
      cycle(1'b0, 1'b1);
      for (int c = 0; c < 40 && r_m != 58; c++) cycle(1'b1, 1'b0);
      chk("reach_58", 128'(fill), 128'(58));
      cycle(1'b1, 1'b1);
      chk("rst_fill", 128'(fill), 128'(0));
      chk("rst_dv", 128'(dout_valid), 128'(0));
      chk("rst_dout", 128'(dout), 128'(0));
      chk("rst_ready", 128'(din_ready), 128'(1));
      for (int c = 0; c < 100; c++) cycle(1'b1, 1'b0);

      // random valid density
      for (int d = 0; d < 3; d++)
         for (int c = 0; c < 300; c++) cycle(($urandom_range(99) < dens[d]), 1'b0);

      // drain: whatever cannot form a full word must still be buffered
      for (int c = 0; c < 10 && r_m >= OW; c++) cycle(1'b0, 1'b0);
      chk("residue", 128'(exp_q.size()), 128'(r_m));

      // parameter sweep
      @(posedge clk); #1 sw_sclr = 1'b1;
      @(posedge clk); #1 sw_sclr = 1'b0; sw_run = 1'b1;
      all_done = 1'b0;
      for (int c = 0; c < 30000 && !all_done; c++) begin
         @(posedge clk);
         all_done = g_sweep[0].done & g_sweep[1].done & g_sweep[2].done &
                    g_sweep[3].done & g_sweep[4].done;
      end
      chk("sweep_done", 128'(all_done), 128'(1'b1));
      #1 sw_run = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
